// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a synchronous FIFO and sends each word as a UART
// frame (start bit, DATA_WIDTH data bits LSB first, stop bit).
// Optional even-parity bit between data and stop: define FIFO_UART_TX_PARITY_EN.
// All outputs are decoded from registered state only, so tx returns high
// immediately when rst_n is asserted.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

`ifdef FIFO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;
`endif

  state_t                state_q, state_d;
  logic [BAUD_W-1:0]     baud_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  baud_last;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                  parity_q;
`endif

  assign baud_last = (baud_cnt == BAUD_LAST);

  // State register; reset lands in IDLE so tx is high straight away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Baud/bit counters and the shift register that feeds the serial line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else if (state_q == LOAD) begin
      shift_q  <= fifo_data;
      bit_cnt  <= '0;
      baud_cnt <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= ^fifo_data;
`endif
    end else if (state_q == IDLE || state_q == FETCH) begin
      baud_cnt <= '0;
    end else begin
      if (baud_last) baud_cnt <= '0;
      else           baud_cnt <= baud_cnt + BAUD_W'(1);
      if (state_q == DATA && baud_last) begin
        shift_q <= shift_q >> 1;
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_d    = state_q;
    fifo_rd_en = 1'b0;
    tx         = 1'b1;
    tx_done    = 1'b0;
    busy       = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = FETCH;
      end
      FETCH: begin
        fifo_rd_en = 1'b1;
        state_d    = LOAD;
      end
      LOAD: begin
        state_d = START;
      end
      START: begin
        tx = 1'b0;
        if (baud_last) state_d = DATA;
      end
      DATA: begin
        tx = shift_q[0];
        if (baud_last && bit_cnt == BIT_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        tx = parity_q;
        if (baud_last) state_d = STOP;
      end
`endif
      STOP: begin
        tx_done = baud_last;
        if (baud_last) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed bench for fifo_uart_tx with CLKS_PER_BIT=4.
// A queue stands in for the FIFO; its pops follow fifo_rd_en at each edge.
// Define FIFO_UART_TX_PARITY_EN to exercise the parity frame.
module tb_fifo_uart_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NB  = DW + 3;
`else
  localparam int NB  = DW + 2;
`endif
  localparam int FRAME = NB * CPB;

  logic          clk;
  logic          rst_n;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_rd_en;
  logic          tx;
  logic          busy;
  logic          tx_done;

  logic [DW-1:0] fifo_q[$];
  int tests_run;
  int tests_failed;
  int rd_pulses;
  int rd_when_empty;
  int rd_consec;
  logic prev_rd;

  fifo_uart_tx #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd_en(fifo_rd_en),
    .tx        (tx),
    .busy      (busy),
    .tx_done   (tx_done)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NB-1:0] exp_frame(input logic [DW-1:0] w);
`ifdef FIFO_UART_TX_PARITY_EN
    return {1'b1, ^w, w, 1'b0};
`else
    return {1'b1, w, 1'b0};
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic [DW-1:0] word);
    fifo_q.push_back(word);
    fifo_empty = 1'b0;
  endtask

  // Advance one clock; the FIFO model pops on the edge where rd_en was high.
  task automatic tick();
    logic rd;
    rd = fifo_rd_en;
    if (rd === 1'b1 && fifo_empty) rd_when_empty++;
    if (rd === 1'b1 && prev_rd === 1'b1) rd_consec++;
    prev_rd = rd;
    @(posedge clk);
    #1;
    if (rd === 1'b1) begin
      rd_pulses++;
      if (fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
    end
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic wait_start(input string tag, output int n);
    n = 0;
    while (tx !== 1'b0 && n < 100) begin
      n++;
      tick();
    end
    checkOutput({tag, "_start_seen"}, {31'd0, tx === 1'b0}, 32'd1);
  endtask

  task automatic capture_frame(input string tag, input logic [DW-1:0] word);
    logic [NB-1:0] got;
    int glitches;
    int done_cnt;
    int done_pos;
    got = '0;
    glitches = 0;
    done_cnt = 0;
    done_pos = -1;
    for (int c = 0; c < FRAME; c++) begin
      if (c % CPB == 0) got[c / CPB] = tx;
      else if (tx !== got[c / CPB]) glitches++;
      if (tx_done === 1'b1) begin
        done_cnt++;
        done_pos = c;
      end
      tick();
    end
    checkOutput({tag, "_bits"}, 32'(got), 32'(exp_frame(word)));
    checkOutput({tag, "_bit_stable"}, glitches, 0);
    checkOutput({tag, "_done_cnt"}, done_cnt, 1);
    checkOutput({tag, "_done_pos"}, done_pos, FRAME - 1);
  endtask

  initial begin
    int n;
    int low_cycles;
    int busy_cycles;
    tests_run = 0;
    tests_failed = 0;
    rd_pulses = 0;
    rd_when_empty = 0;
    rd_consec = 0;
    prev_rd = 1'b0;
    rst_n = 1'b0;
    fifo_empty = 1'b1;
    fifo_data = '0;

    // Reset with a word waiting in the FIFO.
    tick();
    applyStimulus(8'hA5);
    tick();
    tick();
    checkOutput("rst_tx", {31'd0, tx}, 32'd1);
    checkOutput("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_tx_done", {31'd0, tx_done}, 32'd0);
    rst_n = 1'b1;
    rd_pulses = 0;
    checkOutput("rel_rd_before_e1", {31'd0, fifo_rd_en}, 32'd0);
    tick();
    checkOutput("rel_rd_after_e1", {31'd0, fifo_rd_en}, 32'd1);
    tick();
    checkOutput("rel_rd_after_e2", {31'd0, fifo_rd_en}, 32'd0);
    checkOutput("rel_tx_load", {31'd0, tx}, 32'd1);
    tick();
    checkOutput("rel_tx_fall_e3", {31'd0, tx}, 32'd0);

    // Single 0xA5 frame.
    capture_frame("a5", 8'hA5);
`ifndef FIFO_UART_TX_PARITY_EN
    checkOutput("a5_spec_seq", 32'(exp_frame(8'hA5)), 32'h34A);
`endif
    checkOutput("a5_rd_pulses", rd_pulses, 1);
    checkOutput("a5_busy_after", {31'd0, busy}, 32'd0);

    // Back-to-back traffic.
    rd_pulses = 0;
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    applyStimulus(8'h3C);
    wait_start("b2b0", n);
    checkOutput("b2b0_lead", n, 3);
    capture_frame("b2b0", 8'h00);
    wait_start("b2b1", n);
    checkOutput("b2b1_gap", n, 3);
    capture_frame("b2b1", 8'hFF);
    wait_start("b2b2", n);
    checkOutput("b2b2_gap", n, 3);
    capture_frame("b2b2", 8'h3C);
    for (int i = 0; i < 20; i++) tick();
    checkOutput("b2b_rd_pulses", rd_pulses, 3);
    checkOutput("b2b_busy_after", {31'd0, busy}, 32'd0);

    // Empty FIFO for 200 cycles.
    rd_pulses = 0;
    low_cycles = 0;
    busy_cycles = 0;
    for (int i = 0; i < 200; i++) begin
      if (tx !== 1'b1) low_cycles++;
      if (busy !== 1'b0) busy_cycles++;
      tick();
    end
    checkOutput("empty_rd_pulses", rd_pulses, 0);
    checkOutput("empty_tx_low", low_cycles, 0);
    checkOutput("empty_busy", busy_cycles, 0);

    // Reset during DATA bit 3 of 0x5A.
    applyStimulus(8'h5A);
    wait_start("mid", n);
    for (int i = 0; i < 13; i++) tick();
    checkOutput("mid_bit2", {31'd0, tx}, 32'd0);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("mid_bit3", {31'd0, tx}, 32'd1);
    checkOutput("mid_busy_before", {31'd0, busy}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_async_tx", {31'd0, tx}, 32'd1);
    checkOutput("mid_async_busy", {31'd0, busy}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    rd_pulses = 0;
    low_cycles = 0;
    busy_cycles = 0;
    for (int i = 0; i < 60; i++) begin
      if (tx !== 1'b1) low_cycles++;
      if (busy !== 1'b0) busy_cycles++;
      tick();
    end
    checkOutput("mid_no_resend_rd", rd_pulses, 0);
    checkOutput("mid_no_resend_tx", low_cycles, 0);
    checkOutput("mid_no_resend_busy", busy_cycles, 0);

`ifdef FIFO_UART_TX_PARITY_EN
    // Parity frames: 0x07 has odd weight, 0xA5 even.
    applyStimulus(8'h07);
    wait_start("par07", n);
    capture_frame("par07", 8'h07);
    checkOutput("par07_len", FRAME, 44);
    checkOutput("par07_bit", 32'(exp_frame(8'h07) >> (DW + 1)) & 32'd1, 32'd1);
    applyStimulus(8'hA5);
    wait_start("parA5", n);
    capture_frame("parA5", 8'hA5);
    checkOutput("parA5_bit", 32'(exp_frame(8'hA5) >> (DW + 1)) & 32'd1, 32'd0);
`endif

    checkOutput("rd_while_empty", rd_when_empty, 0);
    checkOutput("rd_consecutive", rd_consec, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
